sqrt_nr_iter: RTL and testbench
===============================

Name: sqrt_nr_iter

Overview:
- Parametrised, iterative, non-restoring integer square root unit for the floating_point_alu square_root path.
- Computes root = floor(sqrt(radicand)) and remainder = radicand − root², producing one root bit per clock.
- Replaces the fixed single-bit combinational cells with a sequenced datapath.
- Uses valid/ready handshakes on both input and output, so it can be placed between mantissa pre-normalisation and the rounding stage.

Parameters:
- WIDTH, 16, radicand width in bits. Must be even and ≥ 4; elaborate-time assertion otherwise.
- RW, WIDTH/2, root width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  radicand offered
- in_ready  output  1  unit can accept a radicand
- radicand  input  WIDTH  unsigned operand
- out_valid  output  1  result held stable
- out_ready  input  1  consumer accepts result
- root  output  RW  floor(sqrt(radicand))
- remainder  output  RW+1  radicand − root²
- busy  output  1  iteration in progress

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - state = IDLE; all data registers cleared.
  - in_ready = 1 after deassertion, out_valid = 0, busy = 0, root = 0, remainder = 0.
  - Reset mid-operation aborts the computation; no result is emitted.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready: latch the radicand into shift register D, set Q = 0, R = 0 (signed, RW+2 bits), count = RW−1, go to CALC.
- **CALC (RW cycles):**
  - in_ready = 0, busy = 1.
  - Each cycle, take the next two MSBs p of D (shift D left by 2), then:
    - if R ≥ 0: R' = (R<<2 | p) − (Q<<2 | 01)
    - else: R' = (R<<2 | p) + (Q<<2 | 11)
    - Q' = (Q<<1) | (R' ≥ 0)
  - When count = 0, go to FIX; otherwise decrement count.
- **FIX (1 cycle):**
  - If R < 0, R = R + (Q<<1 | 1); else R is unchanged.
  - Register root = Q and remainder = R[RW:0].
  - Go to DONE.
- **DONE:**
  - out_valid = 1; root and remainder held stable while out_ready = 0.
  - On out_ready, go to IDLE; out_valid falls on the next cycle.
- **Latency:** RW + 2 clocks from input handshake to out_valid (8 + 2 = 10 for WIDTH = 16).
- **Throughput:** one result per RW + 3 clocks with out_ready held high.
- **in_valid outside IDLE** is ignored; the radicand is not sampled.
- **Width rules:**
  - R needs RW+2 signed bits to cover −(2Q+1) … 2Q+1.
  - The final remainder is non-negative and ≤ 2·root, so it fits in RW+1 bits.
  - No overflow is possible.
- **Boundaries:** radicand = 0 gives root 0, remainder 0. Radicand = 2^WIDTH−1 gives root 2^RW−1, remainder 2^(RW+1)−2.

Decomposition:
- Shared package sqrt_pkg:
  - state_t enum {IDLE, CALC, FIX, DONE}
  - localparam function clog2-based count width, $clog2(RW)
  - the step-result struct {r_next, q_bit}
- Sub-module sqrt_nr_step:
  - Combinational single-iteration cell, parametrised by RW.
  - Inputs: R, Q, p. Outputs: R', q_bit.
  - Successor to the per-bit add/subtract select cell; top-level sqrt_nr_iter holds the FSM, counter and registers.

Test Plan:
1. WIDTH=16, radicand=0, out_ready=1 → out_valid 10 clocks after handshake; root=0, remainder=0; in_ready back high one clock later.
2. WIDTH=16, radicand=144 → root=12, remainder=0. Radicand=2 → root=1, remainder=1.
3. WIDTH=16, radicand=65535 → root=255, remainder=510. WIDTH=32 rerun with radicand=0xFFFFFFFF → root=65535, remainder=131070.
4. Back-pressure: out_ready=0 for 5 clocks after out_valid → root/remainder/out_valid stable. A second in_valid with radicand=99 during this window is not accepted (in_ready=0). After out_ready=1 the next handshake yields root=9, remainder=18.
5. Reset mid-CALC: radicand=1000, pulse rst_n low at cycle 4 → out_valid never rises, in_ready=1, busy=0, root=0. A following radicand=1000 → root=31, remainder=39.
6. Random sweep: 10k random radicands at WIDTH=16, 24 and 32 with random out_ready → root² ≤ radicand < (root+1)² and remainder = radicand − root² every transaction.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the iterative non-restoring square-root unit.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest root any instance is expected to produce; sizes the generic step record.
    localparam int MAX_RW = 32;

    typedef struct packed {
        logic signed [MAX_RW+1:0] r_next;
        logic                     q_bit;
    } step_t;

    function automatic int count_width(input int rw);
        return (rw > 1) ? $clog2(rw) : 1;
    endfunction

endpackage

// File: rtl/sqrt_nr_step.sv
// One non-restoring square-root iteration: consumes two radicand bits, yields one root bit.
module sqrt_nr_step #(
    parameter int RW = 8
) (
    input  logic signed [RW+1:0] r,
    input  logic        [RW-1:0] q,
    input  logic        [1:0]    p,
    output logic signed [RW+1:0] r_next,
    output logic                 q_bit
);

    logic signed [RW+1:0] r_sh;
    logic signed [RW+1:0] q_sub;
    logic signed [RW+1:0] q_add;

    // The dropped top bits of R<<2 only wrap modulo 2^(RW+2); the true result always fits.
    always_comb begin
        r_sh   = $signed({r[RW-1:0], p});
        q_sub  = $signed({q, 2'b01});
        q_add  = $signed({q, 2'b11});
        r_next = r[RW+1] ? (r_sh + q_add) : (r_sh - q_sub);
        q_bit  = ~r_next[RW+1];
    end

endmodule

// File: rtl/sqrt_nr_iter.sv
// Sequenced integer square root: one root bit per clock, valid/ready on both sides.
module sqrt_nr_iter
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RW    = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] radicand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    root,
    output logic [RW:0]      remainder,
    output logic             busy
);

    localparam int CW = count_width(RW);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4 || RW != WIDTH / 2) begin : g_bad_width
            $error("sqrt_nr_iter: WIDTH must be even and >= 4, RW must equal WIDTH/2");
        end
    endgenerate

    state_t               state;
    logic [WIDTH-1:0]     d;
    logic [RW-1:0]        q;
    logic signed [RW+1:0] r;
    logic [CW-1:0]        count;

    logic signed [RW+1:0] r_step;
    logic                 q_bit;
    logic signed [RW+1:0] r_fix;

    sqrt_nr_step #(.RW(RW)) u_step (
        .r      (r),
        .q      (q),
        .p      (d[WIDTH-1 -: 2]),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    // A negative partial remainder is restored once, after the last root bit is known.
    assign r_fix = r[RW+1] ? (r + $signed({1'b0, q, 1'b1})) : r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC) || (state == FIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            d         <= '0;
            q         <= '0;
            r         <= '0;
            count     <= '0;
            root      <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d     <= radicand;
                        q     <= '0;
                        r     <= '0;
                        count <= CW'(RW - 1);
                        state <= CALC;
                    end
                end
                CALC: begin
                    d <= {d[WIDTH-3:0], 2'b00};
                    r <= r_step;
                    q <= {q[RW-2:0], q_bit};
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    r         <= r_fix;
                    root      <= q;
                    remainder <= r_fix[RW:0];
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_nr_iter.sv
// Directed bench for sqrt_nr_iter at WIDTH 16, 24 and 32 with a short random property sweep.
module tb_sqrt_nr_iter;

    logic        clk;
    logic        rst_n;
    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        bz   [3];
    logic [31:0] rad;

    logic [7:0]  root16;
    logic [8:0]  rem16;
    logic [11:0] root24;
    logic [12:0] rem24;
    logic [15:0] root32;
    logic [16:0] rem32;

    logic [31:0] root_o [3];
    logic [32:0] rem_o  [3];

    int vectors;
    int fails;

    sqrt_nr_iter #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .radicand(rad[15:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .root(root16), .remainder(rem16), .busy(bz[0])
    );

    sqrt_nr_iter #(.WIDTH(24)) u24 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .radicand(rad[23:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .root(root24), .remainder(rem24), .busy(bz[1])
    );

    sqrt_nr_iter #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .radicand(rad[31:0]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .root(root32), .remainder(rem32), .busy(bz[2])
    );

    assign root_o[0] = {24'd0, root16};
    assign rem_o[0]  = {24'd0, rem16};
    assign root_o[1] = {20'd0, root24};
    assign rem_o[1]  = {20'd0, rem24};
    assign root_o[2] = {16'd0, root32};
    assign rem_o[2]  = {16'd0, rem32};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    // Handshake one radicand, then wait (bounded) for out_valid; lat counts the handshake clock as 1.
    task automatic launch(input int s, input logic [31:0] x, output int lat);
        @(negedge clk);
        rad   = x;
        iv[s] = 1'b1;
        chk("in_ready_idle", 64'(ir[s]), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        iv[s] = 1'b0;
        while (!ov[s] && lat < 80) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic collect(input int s, output logic [31:0] rt, output logic [32:0] rm);
        rt      = root_o[s];
        rm      = rem_o[s];
        ordy[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[s] = 1'b0;
        chk("out_valid_drop", 64'(ov[s]), 64'd0);
        chk("in_ready_back", 64'(ir[s]), 64'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] rt;
        logic [32:0] rm;
        logic [31:0] x;
        logic [63:0] r2;
        logic [63:0] r2n;
        logic        seen;
        int          h;

        vectors = 0;
        fails   = 0;
        rst_n   = 1'b0;
        rad     = '0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(ir[0]), 64'd1);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_busy", 64'(bz[0]), 64'd0);
        chk("rst_root", 64'(root_o[0]), 64'd0);
        chk("rst_remainder", 64'(rem_o[0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero radicand, latency and recovery
        launch(0, 32'd0, lat);
        chk("lat16", 64'(lat), 64'd10);
        collect(0, rt, rm);
        chk("zero_root", 64'(rt), 64'd0);
        chk("zero_rem", 64'(rm), 64'd0);

        launch(0, 32'd144, lat);
        collect(0, rt, rm);
        chk("r144_root", 64'(rt), 64'd12);
        chk("r144_rem", 64'(rm), 64'd0);

        launch(0, 32'd2, lat);
        collect(0, rt, rm);
        chk("r2_root", 64'(rt), 64'd1);
        chk("r2_rem", 64'(rm), 64'd1);

        launch(0, 32'd65535, lat);
        collect(0, rt, rm);
        chk("max16_root", 64'(rt), 64'd255);
        chk("max16_rem", 64'(rm), 64'd510);

        launch(1, 32'hFF_FFFF, lat);
        chk("lat24", 64'(lat), 64'd14);
        collect(1, rt, rm);
        chk("max24_root", 64'(rt), 64'd4095);
        chk("max24_rem", 64'(rm), 64'd8190);

        launch(1, 32'd1000000, lat);
        collect(1, rt, rm);
        chk("r1e6_root", 64'(rt), 64'd1000);
        chk("r1e6_rem", 64'(rm), 64'd0);

        launch(2, 32'hFFFF_FFFF, lat);
        chk("lat32", 64'(lat), 64'd18);
        collect(2, rt, rm);
        chk("max32_root", 64'(rt), 64'd65535);
        chk("max32_rem", 64'(rm), 64'd131070);

        // Back-pressure: result held while a new offer is refused
        launch(0, 32'd50000, lat);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            rad   = 32'd99;
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
            chk("bp_out_valid", 64'(ov[0]), 64'd1);
            chk("bp_root", 64'(root_o[0]), 64'd223);
            chk("bp_rem", 64'(rem_o[0]), 64'd271);
            @(posedge clk);
            @(negedge clk);
        end
        iv[0] = 1'b0;
        collect(0, rt, rm);
        chk("bp_final_root", 64'(rt), 64'd223);
        launch(0, 32'd99, lat);
        collect(0, rt, rm);
        chk("r99_root", 64'(rt), 64'd9);
        chk("r99_rem", 64'(rm), 64'd18);

        // Reset in the middle of an iteration
        @(negedge clk);
        rad   = 32'd1000;
        iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("calc_busy", 64'(bz[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_busy", 64'(bz[0]), 64'd0);
        chk("abort_in_ready", 64'(ir[0]), 64'd1);
        chk("abort_root", 64'(root_o[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        launch(0, 32'd1000, lat);
        collect(0, rt, rm);
        chk("r1000_root", 64'(rt), 64'd31);
        chk("r1000_rem", 64'(rm), 64'd39);

        // Random property sweep with random consumer stalls
        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 60; n++) begin
                x = $urandom;
                if (s == 0) x = x & 32'h0000_FFFF;
                if (s == 1) x = x & 32'h00FF_FFFF;
                launch(s, x, lat);
                h = $urandom_range(0, 3);
                repeat (h) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                collect(s, rt, rm);
                r2  = 64'(rt) * 64'(rt);
                r2n = (64'(rt) + 64'd1) * (64'(rt) + 64'd1);
                chk("rand_lower", 64'(r2 <= 64'(x)), 64'd1);
                chk("rand_upper", 64'(r2n > 64'(x)), 64'd1);
                chk("rand_rem", 64'(rm), 64'(x) - r2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
